// File: rtl/firebird7_in_gate2_ijtag_tdr_reader.sv
// IJTAG TDR reader: one capture-shift-update per accepted start; optional compare under FIREBIRD7_TDR_READER_CMP_EN.
// Latency: done pulses TDR_LEN+2 cycles after accept; starts arriving while busy are dropped, never queued.
module firebird7_in_gate2_ijtag_tdr_reader #(
  parameter int TDR_LEN = 18
) (
  input  logic               ijtag_tck,
  input  logic               ijtag_reset,
  input  logic               start,
  input  logic [TDR_LEN-1:0] wr_data,
`ifdef FIREBIRD7_TDR_READER_CMP_EN
  input  logic [TDR_LEN-1:0] expect_data,
  output logic               mismatch,
`endif
  output logic               busy,
  output logic               done,
  output logic [TDR_LEN-1:0] rd_data,
  output logic               ijtag_sel,
  output logic               ijtag_ce,
  output logic               ijtag_se,
  output logic               ijtag_ue,
  output logic               ijtag_si,
  input  logic               ijtag_so
);

  localparam int CW = $clog2(TDR_LEN + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CAPTURE,
    S_SHIFT,
    S_UPDATE,
    S_DONE
  } state_t;

  state_t             r_state;
  state_t             w_next;
  logic [CW-1:0]      r_cnt;
  logic [TDR_LEN-1:0] r_buf;
  logic [TDR_LEN-1:0] r_rd;
  logic               r_busy;
  logic               r_done;
  logic               r_sel;
  logic               r_ce;
  logic               r_se;
  logic               r_ue;
  logic               r_si;
  logic               w_accept;

  assign w_accept = (r_state == S_IDLE) && start;

  always_ff @(posedge ijtag_tck or negedge ijtag_reset) begin
    if (!ijtag_reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:    if (start) w_next = S_CAPTURE;
      S_CAPTURE: w_next = S_SHIFT;
      S_SHIFT:   if (r_cnt == '0) w_next = S_UPDATE;
      S_UPDATE:  w_next = S_DONE;
      S_DONE:    w_next = S_IDLE;
      default:   w_next = S_IDLE;
    endcase
  end

  // Control outputs are flops decoded from the next state, so they change only on the clock edge.
  always_ff @(posedge ijtag_tck or negedge ijtag_reset) begin
    if (!ijtag_reset) begin
      r_busy <= 1'b0;
      r_done <= 1'b0;
      r_sel  <= 1'b0;
      r_ce   <= 1'b0;
      r_se   <= 1'b0;
      r_ue   <= 1'b0;
    end else begin
      r_busy <= (w_next != S_IDLE);
      r_done <= (w_next == S_DONE);
      r_sel  <= (w_next == S_CAPTURE) || (w_next == S_SHIFT) || (w_next == S_UPDATE);
      r_ce   <= (w_next == S_CAPTURE);
      r_se   <= (w_next == S_SHIFT);
      r_ue   <= (w_next == S_UPDATE);
    end
  end

  // Loaded with TDR_LEN-1 so SHIFT spans counts TDR_LEN-1 down to 0; parks at 0 instead of wrapping.
  always_ff @(posedge ijtag_tck or negedge ijtag_reset) begin
    if (!ijtag_reset) begin
      r_cnt <= '0;
    end else if (r_state == S_CAPTURE) begin
      r_cnt <= CW'(TDR_LEN - 1);
    end else if ((r_state == S_SHIFT) && (r_cnt != '0)) begin
      r_cnt <= r_cnt - 1'b1;
    end
  end

  // si is presented one cycle ahead of the edge that shifts it; so is sampled on every SHIFT edge.
  always_ff @(posedge ijtag_tck or negedge ijtag_reset) begin
    if (!ijtag_reset) begin
      r_buf <= '0;
      r_si  <= 1'b0;
      r_rd  <= '0;
    end else begin
      if (w_accept) begin
        r_buf <= wr_data;
      end else if (w_next == S_SHIFT) begin
        r_buf <= r_buf >> 1;
      end
      r_si <= (w_next == S_SHIFT) ? r_buf[0] : 1'b0;
      if (r_state == S_SHIFT) begin
        r_rd <= {ijtag_so, r_rd[TDR_LEN-1:1]};
      end
    end
  end

`ifdef FIREBIRD7_TDR_READER_CMP_EN
  logic r_mismatch;

  always_ff @(posedge ijtag_tck or negedge ijtag_reset) begin
    if (!ijtag_reset) begin
      r_mismatch <= 1'b0;
    end else if (w_accept) begin
      r_mismatch <= 1'b0;
    end else if (w_next == S_DONE) begin
      r_mismatch <= (r_rd != expect_data);
    end
  end

  assign mismatch = r_mismatch;
`endif

  assign busy      = r_busy;
  assign done      = r_done;
  assign rd_data   = r_rd;
  assign ijtag_sel = r_sel;
  assign ijtag_ce  = r_ce;
  assign ijtag_se  = r_se;
  assign ijtag_ue  = r_ue;
  assign ijtag_si  = r_si;

endmodule

// File: tb/tb_firebird7_in_gate2_ijtag_tdr_reader.sv
// Bench for the IJTAG TDR reader with a behavioural target TDR; define FIREBIRD7_TDR_READER_CMP_EN to cover the compare option.
module tb_firebird7_in_gate2_ijtag_tdr_reader;

  localparam int L = 18;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic [L-1:0] wr_data = '0;
  logic         busy, done, sel, ce, se, ue, si, so;
  logic [L-1:0] rd_data;
`ifdef FIREBIRD7_TDR_READER_CMP_EN
  logic [L-1:0] expect_data = '0;
  logic         mismatch;
`endif

  int errors = 0;
  int checks = 0;

  logic [L-1:0] tdr_sr, tdr_upd, tdr_cap;
  logic [6:0]   tr    [0:63];
  logic [L-1:0] tr_rd [0:63];

  always #5 clk = ~clk;

  firebird7_in_gate2_ijtag_tdr_reader #(.TDR_LEN(L)) dut (
    .ijtag_tck   (clk),
    .ijtag_reset (rst_n),
    .start       (start),
    .wr_data     (wr_data),
`ifdef FIREBIRD7_TDR_READER_CMP_EN
    .expect_data (expect_data),
    .mismatch    (mismatch),
`endif
    .busy        (busy),
    .done        (done),
    .rd_data     (rd_data),
    .ijtag_sel   (sel),
    .ijtag_ce    (ce),
    .ijtag_se    (se),
    .ijtag_ue    (ue),
    .ijtag_si    (si),
    .ijtag_so    (so)
  );

  // Target TDR: capture/shift/update on posedge, serial output retimed on negedge.
  always @(posedge clk) begin
    if (sel) begin
      if (ce)      tdr_sr <= tdr_cap;
      else if (se) tdr_sr <= {si, tdr_sr[L-1:1]};
      if (ue)      tdr_upd <= tdr_sr;
    end
  end
  always @(negedge clk) so <= tdr_sr[0];

  // Expected {busy,done,sel,ce,se,ue,si} for cycle c after the accepting edge.
  function automatic logic [6:0] exp_ctl(input int c, input logic [L-1:0] wr);
    logic b, d, s, e, h, u, i;
    b = (c <= L + 2);
    d = (c == L + 2);
    s = (c <= L + 1);
    e = (c == 0);
    h = (c >= 1) && (c <= L);
    u = (c == L + 1);
    i = 1'b0;
    if (h) i = wr[c-1];
    return {b, d, s, e, h, u, i};
  endfunction

  // Called at a negedge with the DUT idle; returns at the cycle-0 sample point.
  task automatic launch(input logic [L-1:0] wr, input logic [L-1:0] cap);
    wr_data = wr;
    tdr_cap = cap;
    start   = 1'b1;
    @(negedge clk);
    start   = 1'b0;
    wr_data = L'($urandom());
  endtask

  task automatic collect(input int n, input int restart_c);
    for (int c = 0; c < n; c++) begin
      tr[c]    = {busy, done, sel, ce, se, ue, si};
      tr_rd[c] = rd_data;
      start    = (c == restart_c);
      @(negedge clk);
    end
    start = 1'b0;
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if ({busy, done, sel, ce, se, ue, si} !== 7'b0) begin
      errors++;
      $display("FAIL reset_ctl: got %b want 0000000", {busy, done, sel, ce, se, ue, si});
    end
    checks++;
    if (rd_data !== '0) begin
      errors++;
      $display("FAIL reset_rd: got %h want 0", rd_data);
    end
`ifdef FIREBIRD7_TDR_READER_CMP_EN
    checks++;
    if (mismatch !== 1'b0) begin
      errors++;
      $display("FAIL reset_mismatch: got %b want 0", mismatch);
    end
`endif
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_access(input string name, input logic [L-1:0] wr, input logic [L-1:0] cap);
    launch(wr, cap);
    collect(L + 6, -1);
    for (int c = 0; c < L + 6; c++) begin
      checks++;
      if (tr[c] !== exp_ctl(c, wr)) begin
        errors++;
        $display("FAIL %s ctl cycle %0d: got %b want %b", name, c, tr[c], exp_ctl(c, wr));
      end
    end
    checks++;
    if (tr_rd[L+2] !== cap) begin
      errors++;
      $display("FAIL %s rd_at_done: got %h want %h", name, tr_rd[L+2], cap);
    end
    checks++;
    if (tr_rd[L+5] !== cap) begin
      errors++;
      $display("FAIL %s rd_hold: got %h want %h", name, tr_rd[L+5], cap);
    end
    checks++;
    if (tdr_upd !== wr) begin
      errors++;
      $display("FAIL %s tdr_written: got %h want %h", name, tdr_upd, wr);
    end
  endtask

  task automatic test_restart;
    logic [L-1:0] wr, cap;
    int ndone, nbusy, first_low;
    wr  = L'($urandom());
    cap = L'($urandom());
    launch(wr, cap);
    collect(L + 8, 4);
    ndone = 0; nbusy = 0; first_low = -1;
    for (int c = 0; c < L + 8; c++) begin
      if (tr[c][5]) ndone++;
      if (tr[c][6]) nbusy++;
      if (!tr[c][6] && first_low < 0) first_low = c;
    end
    checks++;
    if (ndone != 1) begin
      errors++;
      $display("FAIL restart_done_count: got %0d want 1", ndone);
    end
    checks++;
    if (nbusy != L + 3 || first_low != L + 3) begin
      errors++;
      $display("FAIL restart_busy: got %0d cycles, low at %0d; want %0d, low at %0d", nbusy, first_low, L + 3, L + 3);
    end
    checks++;
    if (tr_rd[L+2] !== cap) begin
      errors++;
      $display("FAIL restart_rd: got %h want %h", tr_rd[L+2], cap);
    end
  endtask

  task automatic test_reset_mid;
    logic [L-1:0] wr, cap;
    int nbad;
    wr  = L'($urandom());
    cap = L'($urandom());
    launch(wr, cap);
    repeat (8) @(negedge clk);
    @(posedge clk);
    #1;
    checks++;
    if (se !== 1'b1) begin
      errors++;
      $display("FAIL midreset_pre_se: got %b want 1", se);
    end
    #1 rst_n = 1'b0;
    #1;
    checks++;
    if ({busy, done, sel, ce, se, ue, si} !== 7'b0 || rd_data !== '0) begin
      errors++;
      $display("FAIL midreset_async: got ctl %b rd %h want 0", {busy, done, sel, ce, se, ue, si}, rd_data);
    end
    nbad = 0;
    repeat (2) begin
      @(negedge clk);
      if (ue || done || busy) nbad++;
    end
    rst_n = 1'b1;
    repeat (L + 4) begin
      @(negedge clk);
      if (ue || done || busy) nbad++;
    end
    checks++;
    if (nbad != 0) begin
      errors++;
      $display("FAIL midreset_aborted: got %0d cycles with ue/done/busy want 0", nbad);
    end
    // Release and start on the same negedge: the first posedge must accept.
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    wr  = L'($urandom());
    cap = L'($urandom());
    launch(wr, cap);
    collect(L + 6, -1);
    for (int c = 0; c < L + 6; c++) begin
      checks++;
      if (tr[c] !== exp_ctl(c, wr)) begin
        errors++;
        $display("FAIL postreset ctl cycle %0d: got %b want %b", c, tr[c], exp_ctl(c, wr));
      end
    end
    checks++;
    if (tr_rd[L+2] !== cap) begin
      errors++;
      $display("FAIL postreset_rd: got %h want %h", tr_rd[L+2], cap);
    end
  endtask

  task automatic test_back_to_back;
    logic [L-1:0] wr, cap;
    int t [0:2];
    logic [L-1:0] rdv [0:2];
    int ndone, nidle;
    wr  = L'($urandom());
    cap = L'($urandom());
    wr_data = wr;
    tdr_cap = cap;
    start   = 1'b1;
    ndone = 0; nidle = 0;
    for (int k = 0; k < 3; k++) begin t[k] = -1; rdv[k] = '0; end
    @(negedge clk);
    for (int s = 0; s < 200 && ndone < 3; s++) begin
      if (!busy && ndone > 0) nidle++;
      if (done) begin
        t[ndone]   = s;
        rdv[ndone] = rd_data;
        ndone++;
      end
      if (ndone == 3) start = 1'b0;
      @(negedge clk);
    end
    start = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if (ndone != 3) begin
      errors++;
      $display("FAIL b2b_count: got %0d done pulses want 3", ndone);
    end
    checks++;
    if (t[0] != L + 2 || t[1] - t[0] != L + 4 || t[2] - t[1] != L + 4) begin
      errors++;
      $display("FAIL b2b_spacing: got %0d,%0d,%0d want %0d,%0d,%0d", t[0], t[1], t[2], L + 2, 2 * L + 6, 3 * L + 10);
    end
    checks++;
    if (nidle != 2) begin
      errors++;
      $display("FAIL b2b_idle: got %0d idle cycles want 2", nidle);
    end
    for (int k = 0; k < 3; k++) begin
      checks++;
      if (rdv[k] !== cap) begin
        errors++;
        $display("FAIL b2b_rd%0d: got %h want %h", k, rdv[k], cap);
      end
    end
    checks++;
    if (busy !== 1'b0 || tdr_upd !== wr) begin
      errors++;
      $display("FAIL b2b_end: got busy %b tdr %h want busy 0 tdr %h", busy, tdr_upd, wr);
    end
  endtask

`ifdef FIREBIRD7_TDR_READER_CMP_EN
  task automatic test_compare(input logic [L-1:0] expv, input logic [L-1:0] cap);
    logic want;
    want = (cap != expv);
    expect_data = expv;
    launch(L'($urandom()), cap);
    checks++;
    if (mismatch !== 1'b0) begin
      errors++;
      $display("FAIL cmp_clear: got %b want 0", mismatch);
    end
    repeat (L + 2) @(negedge clk);
    checks++;
    if (mismatch !== want || done !== 1'b1) begin
      errors++;
      $display("FAIL cmp_done: got mismatch %b done %b want %b 1", mismatch, done, want);
    end
    repeat (3) @(negedge clk);
    checks++;
    if (mismatch !== want) begin
      errors++;
      $display("FAIL cmp_hold: got %b want %b", mismatch, want);
    end
    @(negedge clk);
  endtask
`endif

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    test_reset;
    test_access("capture_31234", L'($urandom()), 18'h31234);
    test_access("write_2AAAA", 18'h2AAAA, L'($urandom()));
    for (int n = 0; n < 6; n++) begin
      test_access("random", L'($urandom()), L'($urandom()));
    end
    test_restart;
    test_reset_mid;
    test_back_to_back;
`ifdef FIREBIRD7_TDR_READER_CMP_EN
    test_compare(18'h31234, 18'h31235);
    test_compare(18'h31234, 18'h31234);
    test_compare(L'($urandom()), L'($urandom()));
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
